ns_pkt_rate_meter: RTL and testbench

NS_PKT_RATE_METER -- requirements
Module: ns_pkt_rate_meter

---
 rtl/ns_rate_pkg.sv | 10 +
 rtl/ns_rate_delta.sv | 35 +++
 rtl/ns_pkt_rate_meter.sv | 125 ++++++++++++
 tb/tb_ns_pkt_rate_meter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ns_rate_pkg.sv
// Shared constants and FSM state type for the packet rate meter.
package ns_rate_pkg;
  localparam int CNT_W = 32;
  localparam int unsigned DEFAULT_INTERVAL = 32'd322265625;

  typedef enum logic {
    BASELINE = 1'b0,
    MEASURE  = 1'b1
  } state_t;
endpackage

// File: rtl/ns_rate_delta.sv
// One counter channel: snapshot register, modular subtractor and registered rate.
module ns_rate_delta
  import ns_rate_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_snap,
  input  logic             load_rate,
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] delta,
  output logic [CNT_W-1:0] rate
);

  logic [CNT_W-1:0] snap_p0;

  // Plain unsigned wrap: counter rollover and upstream counter resets both
  // fall out as the modular difference.
  function automatic logic [CNT_W-1:0] mod_delta(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
    return a - b;
  endfunction

  assign delta = mod_delta(cnt, snap_p0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_p0 <= '0;
      rate    <= '0;
    end else begin
      if (load_snap) snap_p0 <= cnt;
      if (load_rate) rate    <= delta;
    end
  end

endmodule

// File: rtl/ns_pkt_rate_meter.sv
// Per-interval packet rate meter over three free-running counters.
// Optional peak tracking of len4160_rate is enabled by defining NS_RATE_PEAK_EN.
module ns_pkt_rate_meter
  import ns_rate_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_INTERVAL = DEFAULT_INTERVAL
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             sync_clear,
  input  logic [CNT_W-1:0] len4160_packets,
  input  logic [CNT_W-1:0] bad_packets,
  input  logic [CNT_W-1:0] other_packets,
  output logic [CNT_W-1:0] len4160_rate,
  output logic [CNT_W-1:0] bad_rate,
  output logic [CNT_W-1:0] other_rate,
  output logic             rate_valid,
  output logic [CNT_W-1:0] interval_count
`ifdef NS_RATE_PEAK_EN
  ,
  output logic [CNT_W-1:0] peak_len4160_rate
`endif
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLOCKS_PER_INTERVAL - 32'd1);

  logic [1:0]       rst_sync;
  logic             rst;
  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             boundary;
  logic             capture;
  logic [CNT_W-1:0] len_delta;
  logic [CNT_W-1:0] bad_delta_unused;
  logic [CNT_W-1:0] other_delta_unused;

  // Assert immediately with areset, release two edges later in the clk domain.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) rst_sync <= 2'b11;
    else        rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst = rst_sync[1];

  assign boundary = (state == MEASURE) && (timer == '0) && !sync_clear;
  assign capture  = ((state == BASELINE) && !sync_clear) || boundary;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= BASELINE;
      timer          <= '0;
      rate_valid     <= 1'b0;
      interval_count <= '0;
    end else begin
      rate_valid <= boundary;
      if (sync_clear) begin
        state          <= BASELINE;
        interval_count <= '0;
      end else begin
        case (state)
          BASELINE: begin
            timer <= RELOAD;
            state <= MEASURE;
          end
          MEASURE: begin
            if (timer == '0) begin
              timer          <= RELOAD;
              interval_count <= interval_count + 32'd1;
            end else begin
              timer <= timer - 32'd1;
            end
          end
          default: state <= BASELINE;
        endcase
      end
    end
  end

  ns_rate_delta u_len (
    .clk       (clk),
    .rst       (rst),
    .load_snap (capture),
    .load_rate (boundary),
    .cnt       (len4160_packets),
    .delta     (len_delta),
    .rate      (len4160_rate)
  );

  ns_rate_delta u_bad (
    .clk       (clk),
    .rst       (rst),
    .load_snap (capture),
    .load_rate (boundary),
    .cnt       (bad_packets),
    .delta     (bad_delta_unused),
    .rate      (bad_rate)
  );

  ns_rate_delta u_other (
    .clk       (clk),
    .rst       (rst),
    .load_snap (capture),
    .load_rate (boundary),
    .cnt       (other_packets),
    .delta     (other_delta_unused),
    .rate      (other_rate)
  );

`ifdef NS_RATE_PEAK_EN
  // Compare against the live delta so the peak moves on the rate_valid edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_len4160_rate <= '0;
    end else if (sync_clear) begin
      peak_len4160_rate <= '0;
    end else if (boundary && (len_delta > peak_len4160_rate)) begin
      peak_len4160_rate <= len_delta;
    end
  end
`else
  logic [CNT_W-1:0] len_delta_unused;
  assign len_delta_unused = len_delta;
`endif

endmodule

// File: tb/tb_ns_pkt_rate_meter.sv
// Directed, table-driven bench for ns_pkt_rate_meter with a short interval.
module tb_ns_pkt_rate_meter;

  localparam int N = 10;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        sync_clear = 1'b0;
  logic [31:0] len = '0, bad = '0, other = '0;
  logic [31:0] len_rate, bad_rate, other_rate, icount;
  logic        rate_valid;
`ifdef NS_RATE_PEAK_EN
  logic [31:0] peak;
`endif

  int checks = 0;
  int errors = 0;
  bit inc_len = 1'b0;

  typedef struct {
    logic [31:0] len, bad, other;
    logic [31:0] e_len, e_bad, e_other, e_peak;
  } vec_t;
  vec_t tbl[4];

  ns_pkt_rate_meter #(.CLOCKS_PER_INTERVAL(N)) dut (
    .clk             (clk),
    .areset          (areset),
    .sync_clear      (sync_clear),
    .len4160_packets (len),
    .bad_packets     (bad),
    .other_packets   (other),
    .len4160_rate    (len_rate),
    .bad_rate        (bad_rate),
    .other_rate      (other_rate),
    .rate_valid      (rate_valid),
    .interval_count  (icount)
`ifdef NS_RATE_PEAK_EN
    ,
    .peak_len4160_rate (peak)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (inc_len) len = len + 32'd1;
  endtask

  // Steps until rate_valid is seen; returns the number of steps taken.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 0; i < 4 * N + 20; i++) begin
      step();
      cyc++;
      if (rate_valid === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_valid: got timeout after %0d cycles expected rate_valid", cyc);
  endtask

  initial begin
    int cyc;
    int hits;

    tbl[0] = '{32'h00000004, 32'd4,    32'd20,       32'd10, 32'hFFFFFE10, 32'd0,        32'd10};
    tbl[1] = '{32'd54,       32'd4,    32'd27,       32'd50, 32'd0,        32'd7,        32'd50};
    tbl[2] = '{32'd134,      32'd1004, 32'd27,       32'd80, 32'd1000,     32'd0,        32'd80};
    tbl[3] = '{32'd164,      32'd1004, 32'hFFFFFFFF, 32'd30, 32'd0,        32'hFFFFFFE4, 32'd80};

    // Reset state
    for (int i = 0; i < 3; i++) step();
    chk("rst_valid", {31'd0, rate_valid}, 32'd0);
    chk("rst_len_rate", len_rate, 32'd0);
    chk("rst_bad_rate", bad_rate, 32'd0);
    chk("rst_other_rate", other_rate, 32'd0);
    chk("rst_count", icount, 32'd0);

    // len4160 increments every cycle: rate N per interval
    areset  = 1'b0;
    inc_len = 1'b1;
    wait_valid(cyc);
    chk("first_latency", cyc, N + 3);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        wait_valid(cyc);
        chk("inc_gap", cyc, N);
      end
      chk("inc_len_rate", len_rate, N);
      chk("inc_bad_rate", bad_rate, 32'd0);
      chk("inc_other_rate", other_rate, 32'd0);
      chk("inc_count", icount, i + 1);
    end
    step();
    chk("valid_one_cycle", {31'd0, rate_valid}, 32'd0);

    // Clear and rebaseline at known counter values
    inc_len    = 1'b0;
    len        = 32'hFFFFFFFA;
    bad        = 32'd500;
    other      = 32'd20;
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
    chk("clr_valid", {31'd0, rate_valid}, 32'd0);
    chk("clr_count", icount, 32'd0);
    chk("clr_len_hold", len_rate, N);
`ifdef NS_RATE_PEAK_EN
    chk("clr_peak", peak, 32'd0);
`endif
    step();

    // Table: wrap, upstream reset, peak sequence 50/80/30
    for (int i = 0; i < 4; i++) begin
      len   = tbl[i].len;
      bad   = tbl[i].bad;
      other = tbl[i].other;
      wait_valid(cyc);
      chk("tbl_gap", cyc, N);
      chk("tbl_len_rate", len_rate, tbl[i].e_len);
      chk("tbl_bad_rate", bad_rate, tbl[i].e_bad);
      chk("tbl_other_rate", other_rate, tbl[i].e_other);
      chk("tbl_count", icount, i + 1);
`ifdef NS_RATE_PEAK_EN
      chk("tbl_peak", peak, tbl[i].e_peak);
`endif
    end

    // sync_clear on the exact boundary cycle
    hits = 0;
    for (int i = 0; i < N - 1; i++) begin
      step();
      if (rate_valid !== 1'b0) hits++;
      if (len_rate !== 32'd30) hits++;
    end
    chk("mid_interval_quiet", hits, 32'd0);
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
    chk("bclr_valid", {31'd0, rate_valid}, 32'd0);
    chk("bclr_count", icount, 32'd0);
    chk("bclr_len_hold", len_rate, 32'd30);
    chk("bclr_other_hold", other_rate, 32'hFFFFFFE4);
`ifdef NS_RATE_PEAK_EN
    chk("bclr_peak", peak, 32'd0);
`endif
    wait_valid(cyc);
    chk("bclr_gap", cyc, N + 1);
    chk("bclr_count_after", icount, 32'd1);
    chk("bclr_len_rate", len_rate, 32'd0);

    // Nonzero interval, then areset mid-interval
    len = len + 32'd7;
    wait_valid(cyc);
    chk("pre_rst_len_rate", len_rate, 32'd7);
    chk("pre_rst_count", icount, 32'd2);
`ifdef NS_RATE_PEAK_EN
    chk("pre_rst_peak", peak, 32'd7);
`endif
    for (int i = 0; i < 4; i++) step();
    areset = 1'b1;
    #1;
    chk("arst_len_rate", len_rate, 32'd0);
    chk("arst_count", icount, 32'd0);
    chk("arst_valid", {31'd0, rate_valid}, 32'd0);
`ifdef NS_RATE_PEAK_EN
    chk("arst_peak", peak, 32'd0);
`endif
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rate_valid !== 1'b0) hits++;
    end
    chk("arst_quiet", hits, 32'd0);
    areset = 1'b0;
    wait_valid(cyc);
    chk("arst_latency", cyc, N + 3);
    chk("arst_count_after", icount, 32'd1);
    chk("arst_len_after", len_rate, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
